// File: rtl/led_sequence_player.sv
// ---------------------------------------------------------------------------
// led_sequence_player
//
// Memory-mapped LED playback engine. Software pushes a list of 2-bit colour
// codes into a small FIFO with back-to-back stores. The block then plays the
// codes autonomously: each colour lights its LED for ON_CYCLES clocks and is
// followed by GAP_CYCLES dark clocks.
//
// Ports:
//   clock       system clock
//   reset       asynchronous reset, active-low
//   wr_en       one-cycle push strobe (store to the player data address)
//   wr_color    colour code: 00 red, 01 blue, 10 green, 11 yellow
//   clear       one-cycle flush strobe (store to the player control address)
//   status      {20'b0, overflow, busy, full, empty, count[7:0]}
//   red_led     red LED drive, active-high
//   blue_led    blue LED drive, active-high
//   green_led   green LED drive, active-high
//   yellow_led  yellow LED drive, active-high
// ---------------------------------------------------------------------------
module led_sequence_player #(
  parameter int DEPTH      = 16,
  parameter int ON_CYCLES  = 25000000,
  parameter int GAP_CYCLES = 12500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [1:0]  wr_color,
  input  logic        clear,
  output logic [31:0] status,
  output logic        red_led,
  output logic        blue_led,
  output logic        green_led,
  output logic        yellow_led
);

  localparam int MAX_CYCLES = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int TIMER_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam int PTR_W      = $clog2(DEPTH);

  localparam logic [TIMER_W-1:0] ON_RELOAD  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_RELOAD = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [PTR_W-1:0]   LAST_PTR   = PTR_W'(DEPTH - 1);
  localparam logic [7:0]         DEPTH_CNT  = 8'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  logic [1:0]         mem [DEPTH];

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [7:0]         count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [1:0]         cur_color_q, cur_color_d;
  logic [3:0]         led_q, led_d;

  logic               empty;
  logic               full;
  logic               pop;
  logic               push;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Next-state logic for the FIFO bookkeeping, playback FSM and LED drive.
  always_comb begin
    empty       = (count_q == 8'd0);
    full        = (count_q == DEPTH_CNT);
    pop         = 1'b0;
    push        = 1'b0;
    state_d     = state_q;
    timer_d     = timer_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    cur_color_d = cur_color_q;
    led_d       = 4'b0000;

    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
        end
      end
      ST_ON: begin
        if (timer_q == '0) begin
          state_d = ST_GAP;
          timer_d = GAP_RELOAD;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_GAP: begin
        if (timer_q == '0) begin
          if (!empty) begin
            pop = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase

    if (pop) begin
      cur_color_d = mem[rd_ptr_q];
      rd_ptr_d    = next_ptr(rd_ptr_q);
      state_d     = ST_ON;
      timer_d     = ON_RELOAD;
    end

    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted then.
    push = wr_en && (!full || pop);
    if (push) begin
      wr_ptr_d = next_ptr(wr_ptr_q);
    end
    if (wr_en && !push) begin
      overflow_d = 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 8'd1;
      2'b01:   count_d = count_q - 8'd1;
      default: count_d = count_q;
    endcase

    // Flush wins over everything, including a push in the same cycle.
    if (clear) begin
      push       = 1'b0;
      pop        = 1'b0;
      state_d    = ST_IDLE;
      timer_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = 8'd0;
      overflow_d = 1'b0;
    end

    // Decoding from the next state registers the LEDs so they rise on the
    // cycle right after the pop edge.
    if (state_d == ST_ON) begin
      led_d = 4'b0001 << cur_color_d;
    end
  end

  // Control and output registers; reset blanks the LEDs without a clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= 8'd0;
      overflow_q  <= 1'b0;
      cur_color_q <= 2'b00;
      led_q       <= 4'b0000;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      cur_color_q <= cur_color_d;
      led_q       <= led_d;
    end
  end

  // Colour storage needs no reset; the count decides what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_color;
    end
  end

  assign status     = {20'b0, overflow_q, (state_q != ST_IDLE), full, empty, count_q};
  assign red_led    = led_q[0];
  assign blue_led   = led_q[1];
  assign green_led  = led_q[2];
  assign yellow_led = led_q[3];

endmodule

// File: tb/tb_led_sequence_player.sv
// ---------------------------------------------------------------------------
// tb_led_sequence_player
//
// Self-checking bench for led_sequence_player with DEPTH=4, ON_CYCLES=4,
// GAP_CYCLES=2. A reference model keeps the queue of colours and the position
// within the current flash slot (ON + GAP cycles long). The model predicts
// the LEDs and status on every cycle. Directed scenarios add literal
// expectations, and a randomized phase follows them.
// ---------------------------------------------------------------------------
module tb_led_sequence_player;

  localparam int DEPTH = 4;
  localparam int ON    = 4;
  localparam int GAP   = 2;
  localparam int SLOT  = ON + GAP;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_color = 2'b00;
  logic        clear = 1'b0;
  logic [31:0] status;
  logic        red_led;
  logic        blue_led;
  logic        green_led;
  logic        yellow_led;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  // Reference model state: queued colours, current colour, and the slot
  // position (-1 when idle, 0..ON-1 lit, ON..SLOT-1 dark).
  logic [1:0] mq[$];
  logic [1:0] m_cur = 2'b00;
  int         slot = -1;
  bit         m_ovf = 1'b0;

  led_sequence_player #(
    .DEPTH(DEPTH),
    .ON_CYCLES(ON),
    .GAP_CYCLES(GAP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .wr_en(wr_en),
    .wr_color(wr_color),
    .clear(clear),
    .status(status),
    .red_led(red_led),
    .blue_led(blue_led),
    .green_led(green_led),
    .yellow_led(yellow_led)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's worth of inputs, changed on the falling edge.
  task automatic applyStimulus(input logic w, input logic [1:0] c, input logic cl);
    @(negedge clock);
    wr_en    = w;
    wr_color = c;
    clear    = cl;
  endtask

  task automatic step();
    applyStimulus(1'b0, 2'b00, 1'b0);
  endtask

  // Model update: the slot advances each edge; a pop happens whenever the
  // block is idle or finishing a gap and has something queued.
  always @(posedge clock or negedge reset) begin
    bit m_pop;
    if (!reset) begin
      mq.delete();
      slot  = -1;
      m_ovf = 1'b0;
      m_cur = 2'b00;
    end else if (clear) begin
      mq.delete();
      slot  = -1;
      m_ovf = 1'b0;
    end else begin
      m_pop = (mq.size() > 0) && (slot == -1 || slot == SLOT - 1);
      if (m_pop) begin
        m_cur = mq.pop_front();
        slot  = 0;
      end else if (slot == SLOT - 1) begin
        slot = -1;
      end else if (slot >= 0) begin
        slot++;
      end
      if (wr_en) begin
        if (mq.size() < DEPTH) mq.push_back(wr_color);
        else m_ovf = 1'b1;
      end
    end
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clock) begin
    logic [31:0] exp_led;
    logic [31:0] exp_status;
    if (check_en) begin
      exp_led    = (slot >= 0 && slot < ON) ? (32'd1 << m_cur) : 32'd0;
      exp_status = {20'b0, m_ovf, (slot >= 0), (mq.size() == DEPTH),
                    (mq.size() == 0), 8'(mq.size())};
      checkOutput("model_leds", {28'b0, yellow_led, green_led, blue_led, red_led}, exp_led);
      checkOutput("model_status", status, exp_status);
    end
  end

  initial begin
    #500000;
    fails++;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    check_en = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("reset_status", status, 32'h100);
    checkOutput("reset_leds", {28'b0, yellow_led, green_led, blue_led, red_led}, 32'h0);

    // Single green flash: lit from the 2nd through 5th falling edge after
    // the push is driven, dark for two more, then idle.
    applyStimulus(1'b1, 2'b10, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step();
      checkOutput("green_timing", {31'b0, green_led}, {31'b0, (i >= 2 && i <= 5)});
      if (i == 7) checkOutput("busy_in_gap", {31'b0, status[10]}, 32'd1);
    end
    checkOutput("idle_after_flash", status, 32'h100);

    // Back-to-back red, red, yellow.
    applyStimulus(1'b1, 2'b00, 1'b0);
    applyStimulus(1'b1, 2'b00, 1'b0);
    applyStimulus(1'b1, 2'b11, 1'b0);
    repeat (3 * SLOT + 4) step();
    checkOutput("rry_done", status, 32'h100);

    // Six pushes from idle: one is popped, four fill the FIFO, sixth drops.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 2'(i % 4), 1'b0);
    step();
    checkOutput("overflow_status", status, 32'hE04);
    step();
    step();
    checkOutput("blue_after_gap", {28'b0, yellow_led, green_led, blue_led, red_led}, 32'h2);
    applyStimulus(1'b0, 2'b00, 1'b1);
    step();
    checkOutput("clear_status", status, 32'h100);
    checkOutput("clear_leds", {28'b0, yellow_led, green_led, blue_led, red_led}, 32'h0);

    // Push on the exact edge where the gap pops with the FIFO full.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'(3 - (i % 4)), 1'b0);
    step();
    step();
    applyStimulus(1'b1, 2'b01, 1'b0);
    step();
    checkOutput("push_on_pop", status, 32'h604);
    repeat (5 * SLOT + 4) step();
    checkOutput("drain_after_full", status, 32'h100);

    // Fill, drain, refill to exercise pointer wrap-around.
    for (int r = 0; r < 2; r++) begin
      applyStimulus(1'b1, 2'b10, 1'b0);
      applyStimulus(1'b1, 2'b01, 1'b0);
      applyStimulus(1'b1, 2'b11, 1'b0);
      applyStimulus(1'b1, 2'b00, 1'b0);
      repeat (4 * SLOT + 4) step();
    end

    // Asynchronous reset in the middle of a lit red flash.
    applyStimulus(1'b1, 2'b00, 1'b0);
    step();
    step();
    checkOutput("red_before_reset", {31'b0, red_led}, 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_reset_leds", {28'b0, yellow_led, green_led, blue_led, red_led}, 32'h0);
    checkOutput("async_reset_status", status, 32'h100);
    @(negedge clock);
    reset = 1'b1;

    // Randomized traffic with occasional clears and drain periods.
    for (int blk = 0; blk < 5; blk++) begin
      for (int i = 0; i < 100; i++) begin
        applyStimulus(($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0,
                      2'($urandom_range(0, 3)),
                      ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
      end
      repeat (5 * SLOT) step();
    end

    step();
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
